// File: rtl/bht_update_queue_pkg.sv
// Types shared by the BHT update queue: the riscv/ariane_pkg slices it depends on
// and the queue's own storage entry.
package riscv;
   localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
   typedef struct packed {
      logic                   valid;
      logic [riscv::VLEN-1:0] pc;
      logic                   taken;
   } bht_update_t;

   typedef struct packed {
      logic                   valid;
      logic [riscv::VLEN-1:0] pc;
      logic                   taken;
   } bht_resolve_t;
endpackage

package bht_update_queue_pkg;
   typedef struct packed {
      logic [riscv::VLEN-1:0] pc;
      logic                   taken;
   } bht_entry_t;

   function automatic bht_entry_t to_entry(input ariane_pkg::bht_resolve_t r);
      bht_entry_t e;
      e.pc    = r.pc;
      e.taken = r.taken;
      return e;
   endfunction
endpackage

// File: rtl/bht_update_queue.sv
// Two-in / one-out FIFO of resolved branch outcomes feeding the BHT update port.
// Optional statistics counters are built when BHT_UPDATE_STATS_EN is defined.
module bht_update_queue
   import ariane_pkg::*;
   import bht_update_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               debug_mode_i,
   input  bht_resolve_t [1:0] resolve_i,
   output logic               resolve_ready_o,
   output bht_update_t        bht_update_o,
   output logic [31:0]        update_cnt_o,
   output logic [31:0]        taken_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   bht_entry_t        mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              accept, push0, push1, pop;
   logic [1:0]        n_push;

   // Pushes are dropped outright when the producer ignores resolve_ready_o,
   // which keeps the occupancy bounded by DEPTH.
   assign resolve_ready_o = (cnt_q <= CW'(DEPTH - 2));

   always_comb begin
      accept = !flush_i && !debug_mode_i && resolve_ready_o;
      push0  = accept && resolve_i[0].valid;
      push1  = accept && resolve_i[1].valid;
      n_push = {1'b0, push0} + {1'b0, push1};
      pop    = (cnt_q != '0) && !debug_mode_i;
      cnt_d  = cnt_q + CW'(n_push) - CW'(pop);
   end

   // Storage carries no reset; only the count gates validity.
   always_ff @(posedge clk_i) begin
      if (push0) mem_q[wr_ptr_q] <= to_entry(resolve_i[0]);
      if (push1) mem_q[push0 ? wr_ptr_q + AW'(1) : wr_ptr_q] <= to_entry(resolve_i[1]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         wr_ptr_q <= wr_ptr_q + AW'(n_push);
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      bht_update_o.valid = pop;
      bht_update_o.pc    = mem_q[rd_ptr_q].pc;
      bht_update_o.taken = mem_q[rd_ptr_q].taken;
   end

`ifdef BHT_UPDATE_STATS_EN
   logic [31:0] update_cnt_q, taken_cnt_q;

   // A pop in a flush cycle still reaches the BHT, so it is counted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         update_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else if (pop) begin
         update_cnt_q <= update_cnt_q + 32'd1;
         if (mem_q[rd_ptr_q].taken) taken_cnt_q <= taken_cnt_q + 32'd1;
      end
   end

   assign update_cnt_o = update_cnt_q;
   assign taken_cnt_o  = taken_cnt_q;
`else
   assign update_cnt_o = '0;
   assign taken_cnt_o  = '0;
`endif

   count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CW'(DEPTH));

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue (DEPTH=4) with immediate-assertion checks.
module tb_bht_update_queue;
   import ariane_pkg::*;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic               flush_i;
   logic               debug_mode_i;
   bht_resolve_t [1:0] resolve_i;
   logic               resolve_ready_o;
   bht_update_t        bht_update_o;
   logic [31:0]        update_cnt_o;
   logic [31:0]        taken_cnt_o;

   int checks = 0;
   int errors = 0;

   bht_update_queue #(.DEPTH(4)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .debug_mode_i   (debug_mode_i),
      .resolve_i      (resolve_i),
      .resolve_ready_o(resolve_ready_o),
      .bht_update_o   (bht_update_o),
      .update_cnt_o   (update_cnt_o),
      .taken_cnt_o    (taken_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic bht_resolve_t rv(input logic [63:0] pc, input logic t);
      bht_resolve_t r;
      r.valid = 1'b1;
      r.pc    = pc;
      r.taken = t;
      return r;
   endfunction

   task automatic push2(input logic [63:0] pc0, input logic t0,
                        input logic [63:0] pc1, input logic t1);
      resolve_i[0] = rv(pc0, t0);
      resolve_i[1] = rv(pc1, t1);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] q[$];
      logic [63:0] nxt_pc;
      int          cnt_exp;
      int          gaps;
      bit          started;
      int          bound;

      rst_ni = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0; resolve_i = '0;
      #12;
      chk("rst_valid", bht_update_o.valid, 0);
      chk("rst_ready", resolve_ready_o, 1);
      chk("rst_upd_cnt", update_cnt_o, 0);
      chk("rst_tkn_cnt", taken_cnt_o, 0);
      rst_ni = 1'b1;

      // single lane-0 resolution, one-cycle latency
      resolve_i[0] = rv(64'h8000_0010, 1'b1);
      tick();
      resolve_i = '0;
      chk("first_valid", bht_update_o.valid, 1);
      chk("first_pc", bht_update_o.pc, 64'h8000_0010);
      chk("first_taken", bht_update_o.taken, 1);
      tick();
      chk("first_drained", bht_update_o.valid, 0);

      // lane 1 alone, then a two-lane push
      resolve_i[1] = rv(64'h100, 1'b0);
      tick();
      resolve_i = '0;
      chk("l1_valid", bht_update_o.valid, 1);
      chk("l1_pc", bht_update_o.pc, 64'h100);
      chk("l1_taken", bht_update_o.taken, 0);
      push2(64'h104, 1'b1, 64'h108, 1'b0);
      tick();
      resolve_i = '0;
      chk("pair_pc0", bht_update_o.pc, 64'h104);
      chk("pair_tk0", bht_update_o.taken, 1);
      tick();
      chk("pair_valid1", bht_update_o.valid, 1);
      chk("pair_pc1", bht_update_o.pc, 64'h108);
      tick();
      chk("pair_drained", bht_update_o.valid, 0);

      // both lanes pushed whenever ready: order, throttling, 1/cycle drain
      nxt_pc = 64'h1000; gaps = 0; started = 0;
      for (int i = 0; i < 12; i++) begin
         cnt_exp = q.size();
         chk("stream_ready", resolve_ready_o, (cnt_exp <= 2));
         chk("stream_valid", bht_update_o.valid, (cnt_exp != 0));
         if (bht_update_o.valid) begin
            if (q.size() != 0) chk("stream_pc", bht_update_o.pc, q.pop_front());
            started = 1;
         end else if (started) gaps++;
         if (cnt_exp <= 2) begin
            push2(nxt_pc, nxt_pc[2], nxt_pc + 64'd4, 1'b0);
            q.push_back(nxt_pc);
            q.push_back(nxt_pc + 64'd4);
            nxt_pc += 64'd8;
         end else resolve_i = '0;
         tick();
      end
      resolve_i = '0;
      bound = 10;
      while (bht_update_o.valid && bound > 0) begin
         if (q.size() != 0) chk("drain_pc", bht_update_o.pc, q.pop_front());
         else chk("drain_extra", bht_update_o.valid, 0);
         tick();
         bound--;
      end
      chk("stream_left", q.size(), 0);
      chk("stream_gaps", gaps, 0);

      // debug mode: hold 3 entries, discard pushes, resume afterwards
      push2(64'h200, 1'b1, 64'h204, 1'b0);
      tick();
      push2(64'h208, 1'b1, 64'h20C, 1'b1);
      chk("dbg_head", bht_update_o.pc, 64'h200);
      tick();
      resolve_i = '0;
      debug_mode_i = 1'b1;
      resolve_i[0] = rv(64'h300, 1'b1);
      #1;
      chk("dbg_valid_now", bht_update_o.valid, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("dbg_valid", bht_update_o.valid, 0);
         chk("dbg_ready", resolve_ready_o, 0);
      end
      debug_mode_i = 1'b0;
      resolve_i = '0;
      #1;
      chk("dbg_out0", bht_update_o.pc, 64'h204);
      chk("dbg_v0", bht_update_o.valid, 1);
      tick();
      chk("dbg_out1", bht_update_o.pc, 64'h208);
      chk("dbg_v1", bht_update_o.valid, 1);
      tick();
      chk("dbg_out2", bht_update_o.pc, 64'h20C);
      chk("dbg_v2", bht_update_o.valid, 1);
      tick();
      chk("dbg_done", bht_update_o.valid, 0);

      // flush with a simultaneous two-lane push
      push2(64'h400, 1'b0, 64'h404, 1'b0);
      tick();
      push2(64'h408, 1'b0, 64'h40C, 1'b0);
      tick();
      flush_i = 1'b1;
      push2(64'h500, 1'b1, 64'h504, 1'b1);
      #1;
      chk("flush_pop_valid", bht_update_o.valid, 1);
      chk("flush_pop_pc", bht_update_o.pc, 64'h404);
      tick();
      flush_i = 1'b0;
      resolve_i = '0;
      chk("flush_valid", bht_update_o.valid, 0);
      chk("flush_ready", resolve_ready_o, 1);
      tick();
      chk("flush_valid2", bht_update_o.valid, 0);

      // asynchronous reset drops valid without a clock edge
      resolve_i[0] = rv(64'h600, 1'b1);
      tick();
      resolve_i = '0;
      chk("arst_pre", bht_update_o.valid, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_valid", bht_update_o.valid, 0);
      chk("arst_ready", resolve_ready_o, 1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      // statistics: 6 updates, 4 taken
      push2(64'h700, 1'b1, 64'h704, 1'b1);
      tick(); resolve_i = '0; tick(); tick();
      push2(64'h708, 1'b1, 64'h70C, 1'b0);
      tick(); resolve_i = '0; tick(); tick();
      push2(64'h710, 1'b0, 64'h714, 1'b1);
      tick(); resolve_i = '0; tick(); tick();
      chk("stats_idle", bht_update_o.valid, 0);
`ifdef BHT_UPDATE_STATS_EN
      chk("stats_upd", update_cnt_o, 6);
      chk("stats_tkn", taken_cnt_o, 4);
      @(negedge clk_i);
      dut.update_cnt_q = 32'hFFFF_FFFF;
      resolve_i[0] = rv(64'h800, 1'b0);
      tick();
      resolve_i = '0;
      tick();
      chk("stats_wrap", update_cnt_o, 0);
      chk("stats_wrap_tkn", taken_cnt_o, 4);
`else
      chk("stats_upd_off", update_cnt_o, 0);
      chk("stats_tkn_off", taken_cnt_o, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
